// File: rtl/aftab_aau_controller.sv
// Sequencing controller between the AFTAB core and the shared multiply/divide
// unit (AAU). Accepts one M-extension operation at a time, drives the AAU
// start/mode lines, selects the proper result half and strobes doneM.
// Divide-by-zero and signed-overflow divides are resolved locally.
module aftab_aau_controller #(
  parameter int size = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            startM,
  input  logic [2:0]      funct3,
  input  logic [size-1:0] opA,
  input  logic [size-1:0] opB,
  input  logic            flush,
  output logic            readyM,
  output logic            doneM,
  output logic [size-1:0] resultM,
  output logic            dividedByZero,
  output logic [size-1:0] aauA,
  output logic [size-1:0] aauB,
  output logic            multAAU,
  output logic            divideAAU,
  output logic            signedSigned,
  output logic            signedUnsigned,
  output logic            unsignedUnsigned,
  input  logic [size-1:0] H,
  input  logic [size-1:0] L,
  input  logic            completeAAU
);

  typedef enum logic [1:0] {IDLE, BUSY, DRAIN, DONE} state_t;

  localparam logic [size-1:0] MinSigned = {1'b1, {(size-1){1'b0}}};

  state_t          state, nextState;
  logic [2:0]      f3Reg;
  logic            accept;
  logic            divByZeroCase;
  logic            overflowCase;
  logic            shortcut;
  logic            aauActive;
  logic            capture;
  logic [size-1:0] shortResult;
  logic [size-1:0] aauResult;

  assign accept        = startM & readyM & ~flush;
  // Any div/rem with a zero divisor, including DIV/REM.
  assign divByZeroCase = funct3[2] & (opB == '0);
  // Only the signed variants (DIV, REM) can overflow.
  assign overflowCase  = funct3[2] & ~funct3[0] & (opA == MinSigned) & (opB == '1);
  assign shortcut      = divByZeroCase | overflowCase;
  // funct3[1] distinguishes REM/REMU from DIV/DIVU.
  assign shortResult   = divByZeroCase ? (funct3[1] ? opA : '1)
                                       : (funct3[1] ? '0 : opA);
  // MUL and REM/REMU take the low half; all others take the high half.
  assign aauResult     = ((f3Reg == 3'b000) || (f3Reg[2] && f3Reg[1])) ? L : H;
  // A completion that coincides with a flush is dropped, not captured.
  assign capture       = (state == BUSY) & completeAAU & ~flush;
  assign aauActive     = (state == BUSY) || (state == DRAIN);

  // State, operand and result registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state         <= IDLE;
      f3Reg         <= '0;
      aauA          <= '0;
      aauB          <= '0;
      resultM       <= '0;
      dividedByZero <= 1'b0;
    end else begin
      state <= nextState;
      if (accept) begin
        f3Reg <= funct3;
        aauA  <= opA;
        aauB  <= opB;
        if (shortcut) begin
          resultM       <= shortResult;
          dividedByZero <= divByZeroCase;
        end
      end
      if (capture) begin
        resultM       <= aauResult;
        dividedByZero <= 1'b0;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: assigning a default before the case keeps this purely
    // combinational; a missed branch would otherwise infer a latch.
    nextState = state;
    unique case (state)
      IDLE:  if (accept) nextState = shortcut ? DONE : BUSY;
      BUSY: begin
        if (completeAAU)  nextState = flush ? IDLE : DONE;
        else if (flush)   nextState = DRAIN;
      end
      DRAIN: if (completeAAU) nextState = IDLE;
      DONE:  nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Handshake, start and mode lines.
  always_comb begin
    readyM           = (state == IDLE);
    doneM            = (state == DONE) & ~flush;
    multAAU          = aauActive & ~f3Reg[2];
    divideAAU        = aauActive & f3Reg[2];
    signedUnsigned   = aauActive & (f3Reg == 3'b010);
    unsignedUnsigned = aauActive & f3Reg[0] & (f3Reg != 3'b001);
    signedSigned     = aauActive & ~signedUnsigned & ~unsignedUnsigned;
  end

endmodule

// File: tb/tb_aftab_aau_controller.sv
// Scoreboard bench for aftab_aau_controller: the stimulus pushes expected
// results, a monitor pops them whenever doneM is seen. The bench plays the AAU
// by returning hand-computed H/L halves after a fixed delay.
module tb_aftab_aau_controller;

  typedef struct {
    logic [31:0] res;
    logic        dbz;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        startM = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] opA = '0, opB = '0;
  logic        flush = 1'b0;
  logic        readyM, doneM, dividedByZero;
  logic [31:0] resultM, aauA, aauB;
  logic        multAAU, divideAAU, signedSigned, signedUnsigned, unsignedUnsigned;
  logic [31:0] H = '0, L = '0;
  logic        completeAAU = 1'b0;

  int checks = 0;
  int failures = 0;
  exp_t expQ[$];

  localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011,
                         DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;
  localparam logic [2:0] MSS = 3'b100, MSU = 3'b010, MUU = 3'b001;

  aftab_aau_controller #(.size(32)) dut (
    .clk(clk), .rst(rst), .startM(startM), .funct3(funct3), .opA(opA), .opB(opB),
    .flush(flush), .readyM(readyM), .doneM(doneM), .resultM(resultM),
    .dividedByZero(dividedByZero), .aauA(aauA), .aauB(aauB), .multAAU(multAAU),
    .divideAAU(divideAAU), .signedSigned(signedSigned), .signedUnsigned(signedUnsigned),
    .unsignedUnsigned(unsignedUnsigned), .H(H), .L(L), .completeAAU(completeAAU)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: every doneM must match the oldest outstanding expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (doneM === 1'b1) begin
        if (expQ.size() == 0) begin
          check("unexpected_doneM", 64'(doneM), 64'd0);
        end else begin
          exp_t e;
          e = expQ.pop_front();
          check("resultM", 64'(resultM), 64'(e.res));
          check("dividedByZero", 64'(dividedByZero), 64'(e.dbz));
        end
      end
    end
  end

  // Wait (bounded) at a negedge until the controller is ready.
  task automatic waitReady();
    int n = 0;
    while (readyM !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (readyM !== 1'b1) check("ready_timeout", 64'(readyM), 64'd1);
  endtask

  // Issue a request at a negedge; accepted on the following posedge.
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    funct3 = f3;
    opA    = a;
    opB    = b;
    startM = 1'b1;
    @(posedge clk);
    #1 startM = 1'b0;
  endtask

  // One full operation. For AAU ops the bench returns h/l after 4 BUSY cycles.
  task automatic op(input string name, input logic [2:0] f3, input logic [31:0] a,
                    input logic [31:0] b, input logic [31:0] h, input logic [31:0] l,
                    input logic [31:0] expRes, input logic expDbz, input bit sc,
                    input logic [2:0] expMode);
    exp_t e;
    waitReady();
    e.res = expRes;
    e.dbz = expDbz;
    expQ.push_back(e);
    issue(f3, a, b);
    @(negedge clk);  // cycle 1
    if (sc) begin
      check({name, "_short_doneM"}, 64'(doneM), 64'd1);
      check({name, "_short_lines"}, 64'({multAAU, divideAAU}), 64'd0);
    end else begin
      check({name, "_start"}, 64'({multAAU, divideAAU}), f3[2] ? 64'd1 : 64'd2);
      check({name, "_mode"}, 64'({signedSigned, signedUnsigned, unsignedUnsigned}), 64'(expMode));
      check({name, "_operands"}, {aauA, aauB}, {a, b});
      repeat (3) @(negedge clk);
      H = h;
      L = l;
      completeAAU = 1'b1;  // cycle 4
      @(negedge clk);      // cycle 5: doneM
      completeAAU = 1'b0;
      check({name, "_doneM"}, 64'(doneM), 64'd1);
      check({name, "_lines_done"}, 64'({multAAU, divideAAU}), 64'd0);
    end
    @(negedge clk);
    check({name, "_readyM"}, 64'(readyM), 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_readyM", 64'(readyM), 64'd1);
    check("reset_doneM", 64'(doneM), 64'd0);
    check("reset_result", 64'(resultM), 64'd0);
    check("reset_lines", 64'({multAAU, divideAAU, signedSigned, signedUnsigned, unsignedUnsigned}), 64'd0);

    // name  f3  opA  opB  H  L  expected  dbz  shortcut  mode
    op("mulh",   MULH,   32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFF, 1'b0, 1'b0, MSS);
    op("mulhu",  MULHU,  32'hFFFFFFFF, 32'h2, 32'h00000001, 32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b0, MUU);
    op("mulhsu", MULHSU, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFF, 1'b0, 1'b0, MSU);
    op("mul",    MUL,    32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFE, 1'b0, 1'b0, MSS);
    op("div",    DIV,    32'hFFFFFFF9, 32'h2, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b0, MSS);
    op("rem",    REM,    32'hFFFFFFF9, 32'h2, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, MSS);
    op("divu",   DIVU,   32'h7,        32'h2, 32'h3,        32'h1,        32'h3,        1'b0, 1'b0, MUU);
    op("remu",   REMU,   32'h7,        32'h2, 32'h3,        32'h1,        32'h1,        1'b0, 1'b0, MUU);
    op("divu0",  DIVU,   32'h1234,     32'h0, 32'h0,        32'h0,        32'hFFFFFFFF, 1'b1, 1'b1, 3'b0);
    op("remu0",  REMU,   32'h1234,     32'h0, 32'h0,        32'h0,        32'h00001234, 1'b1, 1'b1, 3'b0);
    op("div0",   DIV,    32'h55,       32'h0, 32'h0,        32'h0,        32'hFFFFFFFF, 1'b1, 1'b1, 3'b0);
    op("divovf", DIV,    32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h0,        32'h80000000, 1'b0, 1'b1, 3'b0);
    op("removf", REM,    32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h0,        32'h00000000, 1'b0, 1'b1, 3'b0);
    // DIVU with the same operands is not an overflow case and uses the AAU.
    op("divuovf", DIVU,  32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 32'h0,        1'b0, 1'b0, MUU);

    // Reset for two cycles in the middle of a BUSY operation.
    waitReady();
    issue(MUL, 32'h9, 32'h9);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_readyM", 64'(readyM), 64'd1);
    check("midrst_doneM", 64'(doneM), 64'd0);
    check("midrst_lines", 64'({multAAU, divideAAU}), 64'd0);
    check("midrst_result", 64'(resultM), 64'd0);
    check("midrst_operands", {aauA, aauB}, 64'd0);

    // Flush in the 3rd BUSY cycle of a DIV: drain, no doneM.
    issue(DIV, 32'h64, 32'h5);
    @(negedge clk);            // BUSY 1
    @(negedge clk);            // BUSY 2
    @(negedge clk);            // BUSY 3
    flush = 1'b1;
    @(negedge clk);            // DRAIN
    flush = 1'b0;
    check("drain_divideAAU", 64'(divideAAU), 64'd1);
    check("drain_readyM", 64'(readyM), 64'd0);
    repeat (2) @(negedge clk);
    check("drain_hold", 64'({divideAAU, signedSigned}), 64'd3);
    H = 32'd20;
    L = 32'd0;
    completeAAU = 1'b1;
    @(negedge clk);
    completeAAU = 1'b0;
    check("drain_exit_readyM", 64'(readyM), 64'd1);
    check("drain_exit_doneM", 64'(doneM), 64'd0);
    op("mul3x5", MUL, 32'd3, 32'd5, 32'd0, 32'd15, 32'd15, 1'b0, 1'b0, MSS);

    // Flush in IDLE blocks acceptance.
    @(negedge clk);
    flush = 1'b1;
    issue(DIVU, 32'h7, 32'h0);
    flush = 1'b0;
    @(negedge clk);
    check("idle_flush_noaccept", 64'({readyM, doneM}), 64'd2);

    // Complete and flush together in BUSY: back to IDLE, no doneM.
    issue(MULHU, 32'h2, 32'h3);
    repeat (2) @(negedge clk);
    completeAAU = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    completeAAU = 1'b0;
    flush = 1'b0;
    check("cmpl_flush_idle", 64'({readyM, doneM}), 64'd2);
    check("cmpl_flush_keep_result", 64'(resultM), 64'd15);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 64'(expQ.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aftab_aau_controller.md
# aftab_aau_controller

Sequencing controller between the AFTAB core and the shared multiply/divide unit (AAU). It accepts one RISC-V M-extension operation at a time (funct3-encoded) and drives the AAU start and signedness lines. It captures the correct half of the AAU result and returns a 32-bit result with a one-cycle done strobe. Divide-by-zero and signed-overflow cases are resolved locally without starting the AAU. Flushes are absorbed by draining any in-flight AAU operation.

## Interface
- size, 32, operand/result width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-high
- startM  in  1  operation request, sampled only when readyM=1
- funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- opA, opB  in  size  rs1 and rs2 operands, sampled on accept
- flush  in  1  cancel the current or pending operation
- readyM  out  1  high only in IDLE
- doneM  out  1  one-cycle result-valid strobe
- resultM  out  size  result, valid while doneM=1
- dividedByZero  out  1  high with doneM for a div/rem with opB=0
- aauA, aauB  out  size  registered operands to the AAU
- multAAU, divideAAU  out  1  AAU start lines
- signedSigned, signedUnsigned, unsignedUnsigned  out  1  AAU mode lines, one-hot while busy
- H, L, completeAAU  in  size/size/1  AAU result halves and completion

## Operation
- States: IDLE, BUSY, DRAIN, DONE.
- Accept happens when startM=1, readyM=1 and flush=0. On accept, opA, opB and funct3 are registered.
- Shortcut cases skip the AAU and go to DONE:
  - div/rem with opB=0: quotient = all ones, remainder = opA, dividedByZero=1.
  - DIV/REM with opA=1<<(size-1) and opB=all ones: quotient = opA, remainder = 0.
- All other accepts go IDLE→BUSY.
- Mode mapping:
  - MUL, MULH, DIV, REM → signedSigned.
  - MULHSU → signedUnsigned.
  - MULHU, DIVU, REMU → unsignedUnsigned.
- Start lines:
  - multAAU is high throughout BUSY/DRAIN for funct3[2]=0.
  - divideAAU is high throughout BUSY/DRAIN for funct3[2]=1.
  - Operands and mode lines stay stable in BUSY/DRAIN.
  - In IDLE and DONE, all start and mode lines are 0.
- Result select at completeAAU:
  - MUL → L.
  - MULH, MULHSU, MULHU → H.
  - DIV, DIVU → H (quotient).
  - REM, REMU → L (remainder).
- The selected value is latched into the result register.
- BUSY: completeAAU=1 → latch, go to DONE. flush=1 (without completeAAU) → DRAIN. If completeAAU=1 and flush=1 in the same cycle, go to IDLE with no doneM.
- DRAIN: hold lines until completeAAU=1, then go to IDLE. The result is discarded and doneM is not asserted.
- DONE: doneM = ~flush for exactly one cycle, then IDLE.
- IDLE with flush=1 and startM=1: no accept.
- A new request is accepted no earlier than the cycle after DONE.

## Timing
- Reset (rst=1 at an edge):
  - State goes to IDLE.
  - resultM, dividedByZero, aauA and aauB become 0.
  - All start and mode lines become 0, and doneM=0.
  - readyM=1 from the first cycle after reset.
  - Reset mid-operation abandons the operation; the AAU shares rst.
- AAU path: accept at edge 0 → BUSY from cycle 1, start line high in cycle 1. completeAAU high in cycle n → doneM high in cycle n+1 → readyM high in cycle n+2. Total latency is n+1 cycles.
- Shortcut path: accept at edge 0 → doneM in cycle 1, readyM in cycle 2.
- resultM and dividedByZero hold their value after doneM until the next capture.
- completeAAU is ignored in IDLE and DONE.

## Test plan
- Reset: hold rst for 2 cycles mid-BUSY → next cycle readyM=1, doneM=0, multAAU=divideAAU=0, resultM=0.
- MULH, opA=0xFFFFFFFF, opB=0x00000002 → signedSigned=1 in BUSY; resultM=0xFFFFFFFF. MULHU on the same operands → resultM=0x00000001. MUL → resultM=0xFFFFFFFE.
- DIV, opA=0xFFFFFFF9 (-7), opB=2 → resultM=0xFFFFFFFD. REM → 0xFFFFFFFF. DIVU, opA=7, opB=2 → 3.
- DIVU with opB=0, opA=0x1234 → doneM in cycle 1 with resultM=0xFFFFFFFF and dividedByZero=1; divideAAU never asserted. REMU → resultM=0x1234.
- DIV, opA=0x80000000, opB=0xFFFFFFFF → doneM in cycle 1, resultM=0x80000000. REM → 0.
- Flush in the 3rd BUSY cycle of a DIV → DRAIN, divideAAU held until completeAAU, no doneM. readyM returns 1 in the cycle after completeAAU, and the next MUL (3×5) returns resultM=15.
